// File: rtl/z_seq_wide_adder_pkg.sv
// Shared types and constants for the word-serial wide adder/subtractor.
package z_seq_wide_adder_pkg;

  // Controller states
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam int unsigned DefaultN = 4;
  localparam int unsigned DefaultK = 4;

  // Width needed to index 0..count-1, never less than one bit
  function automatic int unsigned idx_width(input int unsigned count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage

// File: rtl/z_n_rca.sv
// n-bit ripple-carry adder slice, purely combinational.
module z_n_rca #(
  parameter int unsigned n = 4
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         c_in,
  output logic [n-1:0] sum,
  output logic         c_out
);

  // Ripple the carry from bit 0 upward
  always_comb begin
    logic carry;
    carry = c_in;
    sum   = '0;
    for (int i = 0; i < int'(n); i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    c_out = carry;
  end

endmodule

// File: rtl/z_seq_wide_adder.sv
// Word-serial wide adder/subtractor: sequences one n-bit RCA slice over k cycles.
module z_seq_wide_adder
  import z_seq_wide_adder_pkg::*;
#(
  parameter int unsigned n = DefaultN,
  parameter int unsigned k = DefaultK
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           sub,
  input  logic [n*k-1:0] a,
  input  logic [n*k-1:0] b,
  input  logic           c_in,
  output logic           ready,
  output logic           done,
  output logic [n*k-1:0] sum,
  output logic           c_out,
  output logic           ovf
);

  localparam int unsigned W     = n * k;
  localparam int unsigned IdxW  = idx_width(k);
  localparam int unsigned BaseW = idx_width(W);

  state_e          state_q;
  logic [W-1:0]    a_q, b_q, work_q, work_nxt;
  logic            carry_q, op_q;
  logic [IdxW-1:0] idx_q;
  logic [BaseW-1:0] base;
  logic [n-1:0]    slice_a, slice_b, slice_sum;
  logic            slice_co;
  logic            last;

  // Select the active slice and merge its sum into the working result
  always_comb begin
    base     = BaseW'(idx_q * n);
    slice_a  = a_q[base +: n];
    slice_b  = b_q[base +: n];
    work_nxt = work_q;
    work_nxt[base +: n] = slice_sum;
    last     = (idx_q == IdxW'(k - 1));
  end

  z_n_rca #(
    .n(n)
  ) u_rca (
    .a    (slice_a),
    .b    (slice_b),
    .c_in (carry_q),
    .sum  (slice_sum),
    .c_out(slice_co)
  );

  assign ready = (state_q == StIdle) || (state_q == StDone);

  // Controller FSM with registered results; subtract is a + ~b + ~c_in
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      carry_q <= 1'b0;
      op_q    <= 1'b0;
      idx_q   <= '0;
      done    <= 1'b0;
      sum     <= '0;
      c_out   <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          done <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub ? ~c_in : c_in;
            op_q    <= sub;
            idx_q   <= '0;
            work_q  <= '0;
            state_q <= StRun;
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          work_q  <= work_nxt;
          carry_q <= slice_co;
          idx_q   <= idx_q + IdxW'(1);
          if (last) begin
            state_q <= StDone;
            done    <= 1'b1;
            sum     <= work_nxt;
            c_out   <= op_q ? ~slice_co : slice_co;
            ovf     <= (a_q[W-1] == b_q[W-1]) && (work_nxt[W-1] != a_q[W-1]);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
